// File: rtl/shift_reg_out_fifo.sv
// Output buffer for shift_reg_top: packs three lanes into one word and queues it
// behind a first-word-fall-through VALID/READY port. Optional: SHIFT_REG_OUT_FIFO_CHANGE_ONLY_EN.
module shift_reg_out_fifo #(
  parameter int W1    = 12,
  parameter int W2    = 32,
  parameter int W3    = 1,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [W1-1:0]       DATA_1_IN,
  input  logic [W2-1:0]       DATA_2_IN,
  input  logic [W3-1:0]       DATA_3_IN,
  input  logic                WR_EN,
  output logic [W1+W2+W3-1:0] DATA_OUT,
  output logic                VALID_OUT,
  input  logic                READY_IN,
  output logic                FULL,
  output logic                EMPTY,
  output logic [AW:0]         COUNT,
  output logic                OVF_FLAG
);

  localparam int            WW       = W1 + W2 + W3;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_q, count_d;
  logic [WW-1:0] data_out_q, data_out_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic [WW-1:0] in_word;
  logic          wr_req;
  logic          push;
  logic          pop;

  assign in_word = {DATA_3_IN, DATA_2_IN, DATA_1_IN};

`ifdef SHIFT_REG_OUT_FIFO_CHANGE_ONLY_EN
  // Repeated words are filtered before they count as a write request.
  logic [WW-1:0] last_word_q, last_word_d;
  logic          last_valid_q, last_valid_d;

  assign wr_req = WR_EN & (~last_valid_q | (in_word != last_word_q));

  always_comb begin
    last_word_d  = last_word_q;
    last_valid_d = last_valid_q;
    if (push) begin
      last_word_d  = in_word;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_word_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_word_q  <= last_word_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign wr_req = WR_EN;
`endif

  assign pop  = valid_q & READY_IN;
  assign push = wr_req & (~full_q | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_ptr_nxt = rd_ptr_q + PTR_ONE;
    count_d    = count_q;
    data_out_d = data_out_q;
    ovf_d      = ovf_q | (wr_req & full_q & ~pop);

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_nxt;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Head register: when the popped word was the only one, the new head is
    // the word being written this cycle and is not yet in storage.
    if (pop) begin
      if (count_q != CNT_ONE)
        data_out_d = mem_q[rd_ptr_nxt];
      else if (push)
        data_out_d = in_word;
    end else if ((count_q == '0) && push) begin
      data_out_d = in_word;
    end

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    valid_d = (count_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
    end
  end

  assign DATA_OUT  = data_out_q;
  assign VALID_OUT = valid_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign COUNT     = count_q;
  assign OVF_FLAG  = ovf_q;

endmodule

// File: tb/tb_shift_reg_out_fifo.sv
// Bench for shift_reg_out_fifo: a directed vector table, a few directed sequences, and
// randomized traffic, all checked against a queue-based reference model.
module tb_shift_reg_out_fifo;

  localparam int DEPTH = 16;

  logic        CLK;
  logic        RST;
  logic [11:0] DATA_1_IN;
  logic [31:0] DATA_2_IN;
  logic [0:0]  DATA_3_IN;
  logic        WR_EN;
  logic [44:0] DATA_OUT;
  logic        VALID_OUT;
  logic        READY_IN;
  logic        FULL;
  logic        EMPTY;
  logic [4:0]  COUNT;
  logic        OVF_FLAG;

  shift_reg_out_fifo dut (
    .CLK(CLK), .RST(RST),
    .DATA_1_IN(DATA_1_IN), .DATA_2_IN(DATA_2_IN), .DATA_3_IN(DATA_3_IN),
    .WR_EN(WR_EN), .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT), .READY_IN(READY_IN),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVF_FLAG(OVF_FLAG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a plain queue of packed words plus the head and sticky flag.
  logic [44:0] mq[$];
  logic [44:0] m_dout;
  logic        m_ovf;
  logic [44:0] m_last;
  logic        m_last_v;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [11:0] d1;
    logic [31:0] d2;
    logic        d3;
    logic        rdy;
    logic [4:0]  ecount;
    logic        evalid;
    logic [44:0] edout;
  } vec_t;

  vec_t vecs[8];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic modelStep(input logic rst, input logic wr, input logic [44:0] word, input logic rdy);
    logic pop, push, req, full;
    if (rst) begin
      mq.delete();
      m_dout   = '0;
      m_ovf    = 1'b0;
      m_last_v = 1'b0;
      m_last   = '0;
      return;
    end
    req = wr;
`ifdef SHIFT_REG_OUT_FIFO_CHANGE_ONLY_EN
    if (m_last_v && word == m_last) req = 1'b0;
`endif
    full = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && rdy;
    push = req && (!full || pop);
    if (req && full && !pop) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(word);
      m_last   = word;
      m_last_v = 1'b1;
    end
    if (mq.size() > 0) m_dout = mq[0];
  endtask

  task automatic checkOutput();
    checkVal("DATA_OUT", 64'(DATA_OUT), 64'(m_dout));
    checkVal("VALID_OUT", 64'(VALID_OUT), 64'(mq.size() > 0));
    checkVal("COUNT", 64'(COUNT), 64'(mq.size()));
    checkVal("FULL", 64'(FULL), 64'(mq.size() == DEPTH));
    checkVal("EMPTY", 64'(EMPTY), 64'(mq.size() == 0));
    checkVal("OVF_FLAG", 64'(OVF_FLAG), 64'(m_ovf));
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [11:0] d1,
                               input logic [31:0] d2, input logic d3, input logic rdy);
    RST       = rst;
    WR_EN     = wr;
    DATA_1_IN = d1;
    DATA_2_IN = d2;
    DATA_3_IN = d3;
    READY_IN  = rdy;
    @(posedge CLK);
    modelStep(rst, wr, {d3, d2, d1}, rdy);
    #1;
    checkOutput();
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; READY_IN = 1'b0;
    DATA_1_IN = '0; DATA_2_IN = '0; DATA_3_IN = '0;
    mq.delete(); m_dout = '0; m_ovf = 1'b0; m_last = '0; m_last_v = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0, 45'h0};
    vecs[1] = '{1'b0, 1'b1, 12'hFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd1, 1'b1, 45'h1F_FFFF_FFFF_FF};
    vecs[2] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b0, 5'd1, 1'b1, 45'h1F_FFFF_FFFF_FF};
    vecs[3] = '{1'b0, 1'b1, 12'h123, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd2, 1'b1, 45'h1F_FFFF_FFFF_FF};
    vecs[4] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 1'b1, 45'h0D_EAD_BEEF_123};
    vecs[5] = '{1'b0, 1'b1, 12'h456, 32'hCAFE_F00D, 1'b1, 1'b1, 5'd1, 1'b1, 45'h1C_AFE_F00D_456};
    vecs[6] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b1, 5'd0, 1'b0, 45'h1C_AFE_F00D_456};
    vecs[7] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b1, 5'd0, 1'b0, 45'h1C_AFE_F00D_456};

    // Long reset with idle inputs.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkVal("T1_count", 64'(COUNT), 64'd0);
    checkVal("T1_empty", 64'(EMPTY), 64'd1);

    // Directed vector table: single word, hold, pass-through, drain to empty.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].rdy);
      checkVal($sformatf("vec%0d_count", i), 64'(COUNT), 64'(vecs[i].ecount));
      checkVal($sformatf("vec%0d_valid", i), 64'(VALID_OUT), 64'(vecs[i].evalid));
      checkVal($sformatf("vec%0d_dout", i), 64'(DATA_OUT), 64'(vecs[i].edout));
    end

    // Fill past capacity, then drain in order.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b1, 12'(i), '0, 1'b0, 1'b0);
      if (i == 15) checkVal("T3_full_after16", 64'(FULL), 64'd1);
    end
    checkVal("T3_count", 64'(COUNT), 64'd16);
    checkVal("T3_ovf", 64'(OVF_FLAG), 64'd1);
    for (int i = 0; i < 16; i++) begin
      checkVal($sformatf("T3_drain%0d", i), 64'(DATA_OUT[11:0]), 64'(i));
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    end
    checkVal("T3_drained_valid", 64'(VALID_OUT), 64'd0);

    // Full with simultaneous push and pop for 40 cycles.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 12'(100 + i), '0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checkVal($sformatf("T4_head%0d", i), 64'(DATA_OUT[11:0]),
               64'((i < 16) ? (100 + i) : (200 + i - 16)));
      applyStimulus(1'b0, 1'b1, 12'(200 + i), '0, 1'b0, 1'b1);
      checkVal("T4_count", 64'(COUNT), 64'd16);
    end
    checkVal("T4_ovf", 64'(OVF_FLAG), 64'd0);

    // Reset mid-stream with a write pending.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 12'(i + 1), 32'(i), 1'b0, 1'b0);
    checkVal("T5_count7", 64'(COUNT), 64'd7);
    applyStimulus(1'b1, 1'b1, 12'hABC, 32'h1234_5678, 1'b1, 1'b1);
    checkVal("T5_count", 64'(COUNT), 64'd0);
    checkVal("T5_empty", 64'(EMPTY), 64'd1);
    checkVal("T5_valid", 64'(VALID_OUT), 64'd0);

    // Constant lanes: change-only filtering versus plain overflow.
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 12'hFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 12'h000, 32'h0000_0000, 1'b0, 1'b0);
`ifdef SHIFT_REG_OUT_FIFO_CHANGE_ONLY_EN
    checkVal("T6_count", 64'(COUNT), 64'd2);
    checkVal("T6_ovf", 64'(OVF_FLAG), 64'd0);
`else
    checkVal("T6_count", 64'(COUNT), 64'd16);
    checkVal("T6_ovf", 64'(OVF_FLAG), 64'd1);
`endif

    // Randomized traffic with occasional resets; narrow lane values force repeats.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                    12'($urandom_range(0, 3)), 32'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
